// File: rtl/pipelined_cia_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-increment adder.
// The adder sits on the slave side; the operand source / result sink is the master.
interface pipelined_cia_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cia_adder.sv
// Pipelined carry-increment adder/subtractor: one GS-bit group resolved per stage,
// with the inter-group carry registered so the critical path scales with GS.
module pipelined_cia_adder #(
    parameter int N  = 32,
    parameter int GS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_cia_adder_if.slave  bus
);
    localparam int NG = N / GS;

    logic         adv;
    logic         out_valid_q;
    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;

    // Single global enable: everything shifts unless a valid result is being held.
    assign adv          = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    for (genvar k = 0; k < NG; k++) begin : stg
        localparam int W = N - k * GS;

        logic         vld;
        logic         cy;
        logic [N-1:0] x;
        logic [W-1:0] bq;
        logic [GS-1:0] ga;
        logic [GS-1:0] gb;
        logic [GS-1:0] gs;
        logic [GS:0]   raw;
        logic          p;
        logic          co;
        logic [N-1:0]  x_nx;

        // x carries finished sum slices below group k and untouched A slices above it.
        assign ga  = x[k*GS +: GS];
        assign gb  = bq[GS-1:0];
        assign raw = {1'b0, ga} + {1'b0, gb};
        assign p   = &(ga ^ gb);
        assign gs  = raw[GS-1:0] + {{(GS-1){1'b0}}, cy};
        assign co  = raw[GS] | (p & cy);

        always_comb begin
            x_nx = x;
            x_nx[k*GS +: GS] = gs;
        end

        if (k == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= 1'b0;
                    cy  <= 1'b0;
                    x   <= '0;
                    bq  <= '0;
                end else if (adv) begin
                    vld <= bus.in_valid;
                    cy  <= bus.sub | bus.cin;
                    x   <= bus.a;
                    bq  <= bus.sub ? ~bus.b : bus.b;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= 1'b0;
                    cy  <= 1'b0;
                    x   <= '0;
                    bq  <= '0;
                end else if (adv) begin
                    vld <= stg[k-1].vld;
                    cy  <= stg[k-1].co;
                    x   <= stg[k-1].x_nx;
                    bq  <= stg[k-1].bq[W+GS-1:GS];
                end
            end
        end
    end

    logic msb_carry_in;
    assign msb_carry_in = stg[NG-1].x_nx[N-1] ^ stg[NG-1].x[N-1] ^ stg[NG-1].bq[GS-1];

    // Result registers only capture valid beats so sum holds across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= stg[NG-1].vld;
            if (stg[NG-1].vld) begin
                sum_q  <= stg[NG-1].x_nx;
                cout_q <= stg[NG-1].co;
                ovf_q  <= msb_carry_in ^ stg[NG-1].co;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cia_adder.sv
// Randomized and directed bench for pipelined_cia_adder: main 32/8 instance plus
// a sweep of smaller widths/group sizes, all checked against an arithmetic model.
module tb_pipelined_cia_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipelined_cia_adder_if #(.N(32)) bus ();
    pipelined_cia_adder #(.N(32), .GS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int sw_n(int i);
        case (i)
            0: return 16;
            1: return 16;
            2: return 24;
            default: return 8;
        endcase
    endfunction

    function automatic int sw_gs(int i);
        case (i)
            0: return 8;
            1: return 4;
            2: return 2;
            default: return 8;
        endcase
    endfunction

    logic [31:0] sw_a;
    logic [31:0] sw_b;
    logic        sw_cin;
    logic        sw_sub;
    logic        sw_valid;
    logic [31:0] sw_sum [4];
    logic        sw_ov  [4];
    logic        sw_co  [4];
    logic        sw_of  [4];
    logic        sw_ir  [4];

    for (genvar i = 0; i < 4; i++) begin : sw
        localparam int NN = sw_n(i);
        localparam int GG = sw_gs(i);
        pipelined_cia_adder_if #(.N(NN)) ifc ();
        assign ifc.in_valid  = sw_valid;
        assign ifc.a         = sw_a[NN-1:0];
        assign ifc.b         = sw_b[NN-1:0];
        assign ifc.cin       = sw_cin;
        assign ifc.sub       = sw_sub;
        assign ifc.out_ready = 1'b1;
        assign sw_sum[i]     = 32'(ifc.sum);
        assign sw_ov[i]      = ifc.out_valid;
        assign sw_co[i]      = ifc.cout;
        assign sw_of[i]      = ifc.ovf;
        assign sw_ir[i]      = ifc.in_ready;
        pipelined_cia_adder #(.N(NN), .GS(GG)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );
    end

    // Reference: plain integer arithmetic on n-bit values, returns {ovf, cout, sum}.
    function automatic logic [33:0] ref_model(int n, logic [31:0] a, logic [31:0] b,
                                              logic cin, logic sub);
        longint modv, ua, ub, sa, sb, full, sres;
        logic   c, o;
        modv = longint'(1) << n;
        ua   = longint'(a) & (modv - 1);
        ub   = longint'(b) & (modv - 1);
        sa   = (ua >= modv / 2) ? ua - modv : ua;
        sb   = (ub >= modv / 2) ? ub - modv : ub;
        if (sub) begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + longint'(cin);
            c    = (full >= modv);
            sres = sa + sb + longint'(cin);
        end
        o = (sres > modv / 2 - 1) || (sres < -(modv / 2));
        return {o, c, 32'(full & (modv - 1))};
    endfunction

    task automatic test_reset();
        #12;
        total += 4;
        if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.sum !== 32'h0) begin bad++; $display("[TB] FAIL reset_sum: got %h expected 0", bus.sum); end
        if (bus.cout !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout: got %b expected 0", bus.cout); end
        if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000};
        logic [31:0] tb [5] = '{32'h0000_0001, 32'h0, 32'h1, 32'd7, 32'h1};
        logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] es [5] = '{32'h0000_0100, 32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
        logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            int lat;
            @(negedge clk);
            bus.a = ta[i]; bus.b = tb[i]; bus.cin = tc[i]; bus.sub = ts[i];
            bus.out_ready = 1'b1;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            lat = 0;
            while (!bus.out_valid && lat < 20) begin
                @(posedge clk);
                #1 lat++;
            end
            total += 4;
            if (lat != 4) begin bad++; $display("[TB] FAIL dir%0d_latency: got %0d expected 4", i, lat); end
            if (bus.sum !== es[i]) begin bad++; $display("[TB] FAIL dir%0d_sum: got %h expected %h", i, bus.sum, es[i]); end
            if (bus.cout !== ec[i]) begin bad++; $display("[TB] FAIL dir%0d_cout: got %b expected %b", i, bus.cout, ec[i]); end
            if (bus.ovf !== eo[i]) begin bad++; $display("[TB] FAIL dir%0d_ovf: got %b expected %b", i, bus.ovf, eo[i]); end
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_valid_drop: got %b expected 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] q [$];
        logic [33:0] exp_r, prev_out;
        logic        stalled_prev = 1'b0;
        int          accepted = 0;
        int          cyc = 0;
        while ((accepted < 100 || q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            bus.out_ready = (accepted >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.in_valid  = (accepted < 100) && ($urandom_range(0, 3) != 0);
            bus.a   = $urandom;
            bus.b   = $urandom;
            bus.cin = 1'($urandom_range(0, 1));
            bus.sub = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                bad++;
                $display("[TB] FAIL b2b_in_ready: got %b expected %b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            end
            if (stalled_prev) begin
                total++;
                if ({bus.ovf, bus.cout, bus.sum} !== prev_out || bus.out_valid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_stall_hold: got %h/%b expected %h/1", {bus.ovf, bus.cout, bus.sum}, bus.out_valid, prev_out);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_extra_beat: got %h expected none", {bus.ovf, bus.cout, bus.sum});
                end else begin
                    exp_r = q.pop_front();
                    if ({bus.ovf, bus.cout, bus.sum} !== exp_r) begin
                        bad++;
                        $display("[TB] FAIL b2b_result: got %h expected %h", {bus.ovf, bus.cout, bus.sum}, exp_r);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_model(32, bus.a, bus.b, bus.cin, bus.sub));
                accepted++;
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            prev_out = {bus.ovf, bus.cout, bus.sum};
            cyc++;
        end
        total++;
        if (q.size() != 0 || accepted < 100) begin
            bad++;
            $display("[TB] FAIL b2b_timeout: got pending=%0d accepted=%0d expected pending=0 accepted=100", q.size(), accepted);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [33:0] exp_r;
        int          lat, stale;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a = $urandom; bus.b = $urandom; bus.cin = 1'b1; bus.sub = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total += 5;
        if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.sum !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_sum: got %h expected 0", bus.sum); end
        if (bus.cout !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_cout: got %b expected 0", bus.cout); end
        if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_ovf: got %b expected 0", bus.ovf); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_in_ready: got %b expected 1", bus.in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (bus.out_valid) stale++;
        end
        total++;
        if (stale != 0) begin bad++; $display("[TB] FAIL mid_rst_stale: got %0d beats expected 0", stale); end
        @(negedge clk);
        bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b1; bus.sub = 1'b0;
        exp_r = ref_model(32, bus.a, bus.b, bus.cin, bus.sub);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        total += 2;
        if (lat != 4) begin bad++; $display("[TB] FAIL mid_rst_latency: got %0d expected 4", lat); end
        if ({bus.ovf, bus.cout, bus.sum} !== exp_r) begin bad++; $display("[TB] FAIL mid_rst_result: got %h expected %h", {bus.ovf, bus.cout, bus.sum}, exp_r); end
    endtask

    task automatic test_param_sweep();
        for (int beat = 0; beat < 8; beat++) begin
            logic        seen [4];
            int          lat  [4];
            logic [33:0] got  [4];
            logic [33:0] exp_r;
            @(negedge clk);
            sw_a = $urandom; sw_b = $urandom;
            sw_cin = 1'($urandom_range(0, 1));
            sw_sub = (beat % 2 == 1);
            sw_valid = 1'b1;
            #1;
            for (int i = 0; i < 4; i++) begin
                total++;
                if (sw_ir[i] !== 1'b1) begin bad++; $display("[TB] FAIL sweep%0d_in_ready: got %b expected 1", i, sw_ir[i]); end
                seen[i] = 1'b0; lat[i] = 0; got[i] = '0;
            end
            @(posedge clk);
            #1 sw_valid = 1'b0;
            for (int c = 1; c <= 16; c++) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    if (!seen[i] && sw_ov[i]) begin
                        seen[i] = 1'b1;
                        lat[i]  = c;
                        got[i]  = {sw_of[i], sw_co[i], sw_sum[i]};
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                exp_r = ref_model(sw_n(i), sw_a, sw_b, sw_cin, sw_sub);
                total += 2;
                if (lat[i] != sw_n(i) / sw_gs(i)) begin
                    bad++;
                    $display("[TB] FAIL sweep%0d_latency: got %0d expected %0d", i, lat[i], sw_n(i) / sw_gs(i));
                end
                if (got[i] !== exp_r) begin
                    bad++;
                    $display("[TB] FAIL sweep%0d_result: got %h expected %h", i, got[i], exp_r);
                end
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
